// File: rtl/result_tx_sequencer.sv
// Frames one {opcode, 16-bit result} request as HEADER/opcode/result_hi/result_lo[/xor] bytes
// and hands them one at a time to the shared UART transmitter, watching its busy flag.
module result_tx_sequencer #(
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter bit          CSUM_EN        = 1'b1,
    parameter int unsigned ACCEPT_TIMEOUT = 16      // legal range 2..255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_opcode,
    input  logic [15:0] req_result,
    output logic        uart_start,
    output logic [7:0]  uart_data,
    input  logic        uart_busy,
    output logic        frame_done,
    output logic        err_timeout,
    output logic [7:0]  frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACC,
        WAIT_DONE,
        DONE
    } state_t;

    localparam logic [2:0] LAST_IDX     = CSUM_EN ? 3'd4 : 3'd3;
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACCEPT_TIMEOUT - 1);

    state_t      state;
    logic [2:0]  idx;
    logic [7:0]  wait_cnt;
    logic [2:0]  opcode_q;
    logic [15:0] result_q;
    logic [7:0]  cur_byte;

    // Byte selected by the current index; the checksum is rebuilt from the latched request.
    always_comb begin
        cur_byte = HEADER;
        case (idx)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = {5'b0, opcode_q};
            3'd2:    cur_byte = result_q[15:8];
            3'd3:    cur_byte = result_q[7:0];
            default: cur_byte = HEADER ^ {5'b0, opcode_q} ^ result_q[15:8] ^ result_q[7:0];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            uart_start  <= 1'b0;
            uart_data   <= 8'h00;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            frame_count <= 8'h00;
            idx         <= 3'd0;
            wait_cnt    <= 8'h00;
            opcode_q    <= 3'd0;
            result_q    <= 16'h0000;
        end else begin
            // NOTE: pulse outputs default low each cycle; only the branch that fires raises them.
            uart_start <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        opcode_q    <= req_opcode;
                        result_q    <= req_result;
                        idx         <= 3'd0;
                        err_timeout <= 1'b0;
                        req_ready   <= 1'b0;
                        state       <= START;
                    end
                end
                START: begin
                    if (!uart_busy) begin
                        uart_start <= 1'b1;
                        uart_data  <= cur_byte;
                        wait_cnt   <= 8'h00;
                        state      <= WAIT_ACC;
                    end
                end
                WAIT_ACC: begin
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        // Transmitter never took the byte: drop the frame and flag it.
                        err_timeout <= 1'b1;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        if (idx == LAST_IDX) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                            state       <= DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= START;
                        end
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Directed + randomized bench for result_tx_sequencer: two instances (checksum on/off), each
// driving its own behavioural UART that logs every byte it is started with.
module tb_result_tx_sequencer;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid [2];
    logic [2:0]  opcode;
    logic [15:0] result;

    logic        ready [2];
    logic        start [2];
    logic [7:0]  data  [2];
    logic        busy  [2];
    logic        done  [2];
    logic        err   [2];
    logic [7:0]  count [2];

    logic        mbusy      [2] = '{1'b0, 1'b0};
    logic        prev_start [2] = '{1'b0, 1'b0};
    int          rem        [2] = '{0, 0};
    int          cap_n      [2] = '{0, 0};
    int          done_n     [2] = '{0, 0};
    int          viol = 0;
    logic [7:0]  cap_mem [2][0:2047];
    logic        ext_busy [2];
    logic        dead     [2];
    int          busy_len;

    logic [7:0]  exp_mem [0:1023];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    int          wait_timeouts = 0;

    always #5 clock = ~clock;

    assign busy[0] = mbusy[0] | ext_busy[0];
    assign busy[1] = mbusy[1] | ext_busy[1];

    result_tx_sequencer #(.HEADER(8'hA5), .CSUM_EN(1'b1), .ACCEPT_TIMEOUT(TO)) dut_csum (
        .clock(clock), .reset(reset),
        .req_valid(valid[0]), .req_ready(ready[0]),
        .req_opcode(opcode), .req_result(result),
        .uart_start(start[0]), .uart_data(data[0]), .uart_busy(busy[0]),
        .frame_done(done[0]), .err_timeout(err[0]), .frame_count(count[0])
    );

    result_tx_sequencer #(.HEADER(8'hA5), .CSUM_EN(1'b0), .ACCEPT_TIMEOUT(TO)) dut_plain (
        .clock(clock), .reset(reset),
        .req_valid(valid[1]), .req_ready(ready[1]),
        .req_opcode(opcode), .req_result(result),
        .uart_start(start[1]), .uart_data(data[1]), .uart_busy(busy[1]),
        .frame_done(done[1]), .err_timeout(err[1]), .frame_count(count[1])
    );

    // Behavioural UART: takes a byte on start, stays busy for busy_len cycles, logs the byte.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            prev_start[i] <= start[i];
            if (start[i] && (prev_start[i] || busy[i])) viol <= viol + 1;
            if (done[i]) done_n[i] <= done_n[i] + 1;
            if (start[i]) begin
                if (cap_n[i] < 2048) cap_mem[i][cap_n[i]] <= data[i];
                cap_n[i] <= cap_n[i] + 1;
                if (!dead[i] && !mbusy[i]) begin
                    mbusy[i] <= 1'b1;
                    rem[i]   <= busy_len;
                end
            end else if (mbusy[i]) begin
                if (rem[i] <= 1) mbusy[i] <= 1'b0;
                else rem[i] <= rem[i] - 1;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, opcode, result high, result low, then XOR of the four.
    function automatic logic [7:0] frame_byte(input logic [2:0] op, input logic [15:0] r, input int k);
        logic [7:0] b [4];
        b[0] = 8'hA5;
        b[1] = {5'b0, op};
        b[2] = r[15:8];
        b[3] = r[7:0];
        if (k < 4) return b[k];
        return b[0] ^ b[1] ^ b[2] ^ b[3];
    endfunction

    task automatic check_frame(input string tag, input int i, input int base,
                               input logic [2:0] op, input logic [15:0] r, input bit csum);
        int n;
        n = csum ? 5 : 4;
        check({tag, "_nbytes"}, 32'(cap_n[i] - base), 32'(n));
        for (int k = 0; k < n; k++)
            check($sformatf("%s_byte%0d", tag, k), {24'h0, cap_mem[i][base + k]},
                  {24'h0, frame_byte(op, r, k)});
    endtask

    // Present a request, wait for acceptance, then scramble inputs to prove they were latched.
    task automatic send(input int i, input logic [2:0] op, input logic [15:0] r);
        int k;
        @(negedge clock);
        opcode   = op;
        result   = r;
        valid[i] = 1'b1;
        k = 0;
        while (!ready[i] && k < 500) begin
            @(negedge clock);
            k++;
        end
        if (!ready[i]) wait_timeouts++;
        @(posedge clock);
        @(negedge clock);
        valid[i] = 1'b0;
        opcode   = 3'($urandom);
        result   = 16'($urandom);
    endtask

    task automatic wait_frame(input int i, input bit expect_done, input string tag);
        int   k;
        logic last;
        k = 0;
        last = 1'b0;
        while (!ready[i] && k < 3000) begin
            last = done[i];
            @(negedge clock);
            k++;
        end
        if (!ready[i]) wait_timeouts++;
        else if (expect_done) check({tag, "_done_then_ready"}, {31'h0, last}, 32'h1);
    endtask

    initial begin
        int          base;
        int          dn;
        int          n;
        int          k;
        int          bad;
        logic        saw;
        logic [2:0]  op;
        logic [15:0] r;

        valid    = '{1'b0, 1'b0};
        ext_busy = '{1'b0, 1'b0};
        dead     = '{1'b0, 1'b0};
        busy_len = 10;
        opcode   = 3'd0;
        result   = 16'h0000;

        repeat (3) @(negedge clock);
        check("rst_ready",  {31'h0, ready[0]}, 32'h1);
        check("rst_start",  {31'h0, start[0]}, 32'h0);
        check("rst_data",   {24'h0, data[0]},  32'h0);
        check("rst_done",   {31'h0, done[0]},  32'h0);
        check("rst_err",    {31'h0, err[0]},   32'h0);
        check("rst_count",  {24'h0, count[0]}, 32'h0);
        check("rst_count1", {24'h0, count[1]}, 32'h0);
        reset = 1'b0;

        // 1: checksum frame, start pulse one cycle after the accept edge.
        base = cap_n[0];
        dn   = done_n[0];
        send(0, 3'd3, 16'h1234);
        check("t1_no_start_in_start_state", {31'h0, start[0]}, 32'h0);
        @(negedge clock);
        check("t1_start_latency", {31'h0, start[0]}, 32'h1);
        check("t1_first_data", {24'h0, data[0]}, 32'hA5);
        wait_frame(0, 1'b1, "t1");
        check_frame("t1", 0, base, 3'd3, 16'h1234, 1'b1);
        check("t1_csum_literal", {24'h0, cap_mem[0][base + 4]}, 32'h80);
        check("t1_done_pulses", 32'(done_n[0] - dn), 32'd1);
        check("t1_count", {24'h0, count[0]}, 32'd1);

        // 2: no checksum byte when disabled.
        base = cap_n[1];
        dn   = done_n[1];
        send(1, 3'd7, 16'hFFFF);
        wait_frame(1, 1'b1, "t2");
        check_frame("t2", 1, base, 3'd7, 16'hFFFF, 1'b0);
        check("t2_done_pulses", 32'(done_n[1] - dn), 32'd1);
        check("t2_count", {24'h0, count[1]}, 32'd1);

        // 3: transmitter never accepts; timeout measured from the first start pulse.
        dead[0] = 1'b1;
        base = cap_n[0];
        dn   = done_n[0];
        send(0, 3'd1, 16'h0055);
        k = 0;
        while (!start[0] && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!start[0]) wait_timeouts++;
        n = 0;
        while (!err[0] && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("t3_timeout_cycles", 32'(n), 32'(TO));
        check("t3_back_to_idle", {31'h0, ready[0]}, 32'h1);
        check("t3_count_kept", {24'h0, count[0]}, 32'd1);
        check("t3_no_done", 32'(done_n[0] - dn), 32'd0);
        check("t3_single_start", 32'(cap_n[0] - base), 32'd1);
        dead[0] = 1'b0;
        op = 3'($urandom);
        r  = 16'($urandom);
        base = cap_n[0];
        send(0, op, r);
        check("t3_err_cleared", {31'h0, err[0]}, 32'h0);
        wait_frame(0, 1'b1, "t3");
        check_frame("t3", 0, base, op, r, 1'b1);
        check("t3_count", {24'h0, count[0]}, 32'd2);

        // 4: busy held high across the accept; start must wait for it to drop.
        ext_busy[0] = 1'b1;
        base = cap_n[0];
        op = 3'($urandom);
        r  = 16'($urandom);
        send(0, op, r);
        saw = 1'b0;
        repeat (20) begin
            if (start[0]) saw = 1'b1;
            @(negedge clock);
        end
        check("t4_no_start_while_busy", {31'h0, saw}, 32'h0);
        ext_busy[0] = 1'b0;
        k = 0;
        while (!start[0] && k < 10) begin
            @(negedge clock);
            k++;
        end
        check("t4_start_after_release", {31'h0, start[0]}, 32'h1);
        check("t4_header", {24'h0, data[0]}, 32'hA5);
        wait_frame(0, 1'b1, "t4");
        check_frame("t4", 0, base, op, r, 1'b1);

        // 5: reset in the middle of byte 2, then a fresh frame from the header.
        base = cap_n[0];
        send(0, 3'd6, 16'h0A0B);
        k = 0;
        while (cap_n[0] - base < 3 && k < 500) begin
            @(negedge clock);
            k++;
        end
        if (cap_n[0] - base < 3) wait_timeouts++;
        repeat (3) @(negedge clock);
        check("t5_byte2_in_flight", {24'h0, cap_mem[0][base + 2]}, 32'h0A);
        reset = 1'b1;
        #1;
        check("t5_rst_start", {31'h0, start[0]}, 32'h0);
        check("t5_rst_ready", {31'h0, ready[0]}, 32'h1);
        check("t5_rst_data",  {24'h0, data[0]},  32'h0);
        check("t5_rst_count", {24'h0, count[0]}, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        base = cap_n[0];
        op = 3'($urandom);
        r  = 16'($urandom);
        send(0, op, r);
        wait_frame(0, 1'b1, "t5");
        check_frame("t5", 0, base, op, r, 1'b1);
        check("t5_count", {24'h0, count[0]}, 32'd1);

        // 6: 256 back-to-back frames, valid held high, new random values after each accept.
        busy_len = 2;
        base = cap_n[1];
        dn   = done_n[1];
        @(negedge clock);
        opcode   = 3'($urandom);
        result   = 16'($urandom);
        valid[1] = 1'b1;
        for (int f = 0; f < 256; f++) begin
            k = 0;
            while (!ready[1] && k < 500) begin
                @(negedge clock);
                k++;
            end
            if (!ready[1]) wait_timeouts++;
            for (int b = 0; b < 4; b++) exp_mem[f * 4 + b] = frame_byte(opcode, result, b);
            @(posedge clock);
            @(negedge clock);
            opcode = 3'($urandom);
            result = 16'($urandom);
        end
        k = 0;
        while (!ready[1] && k < 500) begin
            @(negedge clock);
            k++;
        end
        valid[1] = 1'b0;
        if (!ready[1]) wait_timeouts++;
        bad = 0;
        for (int b = 0; b < 1024; b++)
            if (cap_mem[1][base + b] !== exp_mem[b]) bad++;
        check("t6_nbytes", 32'(cap_n[1] - base), 32'd1024);
        check("t6_bytes_wrong", 32'(bad), 32'd0);
        check("t6_done_pulses", 32'(done_n[1] - dn), 32'd256);
        check("t6_count_wrapped", {24'h0, count[1]}, 32'd0);

        repeat (3) @(negedge clock);
        check("protocol_violations", 32'(viol), 32'd0);
        check("bounded_waits_expired", 32'(wait_timeouts), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
